// File: rtl/pio_sm_core.sv
// PIO state-machine sequencer: fetches via pc and executes JMP, WAIT and SET
// with per-instruction delay, program wrap and an externally forced jump.
module pio_sm_core #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int PIN_W   = 32,
  parameter int DELAY_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [15:0]       instruction,
  input  logic [ADDR_W-1:0] wrap_bottom,
  input  logic [ADDR_W-1:0] wrap_top,
  input  logic [PIN_W-1:0]  pins_in,
  input  logic [4:0]        jmp_pin,
  input  logic              osr_empty,
  input  logic              force_jmp_en,
  input  logic [ADDR_W-1:0] force_jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [PIN_W-1:0]  pins_out,
  output logic              stalled
);

  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_WAIT = 3'b001;
  localparam logic [2:0] OP_SET  = 3'b111;

  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [ADDR_W-1:0]  pc_d;
  logic [DATA_W-1:0]  x_d, y_d;
  logic [PIN_W-1:0]   pins_d;
  logic               stalled_d;

  logic [2:0]         opcode, arg;
  logic [4:0]         idx;
  logic [DELAY_W-1:0] dly;
  logic [ADDR_W-1:0]  seq, target;
  logic               jmp_take, wait_block;

  assign opcode = instruction[15:13];
  assign arg    = instruction[7:5];
  assign idx    = instruction[4:0];
  assign dly    = instruction[8 +: DELAY_W];
  assign target = ADDR_W'(idx);
  assign seq    = (pc == wrap_top) ? wrap_bottom : pc + ADDR_W'(1);

  // JMP conditions look at pre-decrement X/Y
  always_comb begin
    jmp_take = 1'b0;
    case (arg)
      3'b000: jmp_take = 1'b1;
      3'b001: jmp_take = (x == '0);
      3'b010: jmp_take = (x != '0);
      3'b011: jmp_take = (y == '0);
      3'b100: jmp_take = (y != '0);
      3'b101: jmp_take = (x != y);
      3'b110: jmp_take = pins_in[jmp_pin];
      default: jmp_take = !osr_empty;
    endcase
  end

  // IRQ and reserved wait sources never block
  assign wait_block = (opcode == OP_WAIT) && !arg[1] && (pins_in[idx] != arg[2]);

  always_comb begin
    pc_d      = pc;
    x_d       = x;
    y_d       = y;
    pins_d    = pins_out;
    delay_d   = delay_q;
    stalled_d = stalled;
    if (force_jmp_en) begin
      pc_d      = force_jmp_addr;
      delay_d   = '0;
      stalled_d = 1'b0;
    end else if (!en) begin
      pc_d = pc;
    end else if (delay_q != '0) begin
      delay_d   = delay_q - DELAY_W'(1);
      stalled_d = (delay_q != DELAY_W'(1));
    end else begin
      pc_d    = seq;
      delay_d = dly;
      case (opcode)
        OP_JMP: begin
          if (jmp_take) pc_d = target;
          if (arg == 3'b010) x_d = x - DATA_W'(1);
          if (arg == 3'b100) y_d = y - DATA_W'(1);
        end
        OP_WAIT: begin
          if (wait_block) begin
            pc_d    = pc;
            delay_d = '0;
          end
        end
        OP_SET: begin
          case (arg)
            3'b000:  pins_d[4:0] = idx;
            3'b001:  x_d = DATA_W'(idx);
            3'b010:  y_d = DATA_W'(idx);
            default: x_d = x;
          endcase
        end
        default: pc_d = seq;
      endcase
      stalled_d = wait_block || (delay_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      x        <= '0;
      y        <= '0;
      pins_out <= '0;
      delay_q  <= '0;
      stalled  <= 1'b0;
    end else begin
      pc       <= pc_d;
      x        <= x_d;
      y        <= y_d;
      pins_out <= pins_d;
      delay_q  <= delay_d;
      stalled  <= stalled_d;
    end
  end

endmodule
